qos_ingress: RTL and testbench

//  Upstream feeder of the qos block. Holds one word per virtual channel (VC).

---
 rtl/qos_ingress.sv | 140 ++++++++++++++
 tb/tb_qos_ingress.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/qos_ingress.sv
// qos_ingress: one-word-per-VC holding stage feeding the qos write port, with
// per-VC pausa/continuar back-pressure and round-robin arbitration.
// Optional per-VC stall counters are built when QOS_INGRESS_STALL_CNT_EN is defined.
module qos_ingress #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned BUF_WIDTH      = 3,
  parameter int unsigned STALL_CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic                              in_valid,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0] in_vc,
  input  logic [BUF_WIDTH:0]                in_data,
  output logic                              in_ready,
  input  logic [QUEUE_QUANTITY-1:0]         pausa,
  input  logic [QUEUE_QUANTITY-1:0]         continuar,
  output logic                              wr_en,
  output logic [$clog2(QUEUE_QUANTITY)-1:0] vc_id,
  output logic [BUF_WIDTH:0]                data_word,
  output logic [QUEUE_QUANTITY-1:0]         paused,
  output logic                              idle
`ifdef QOS_INGRESS_STALL_CNT_EN
  ,output logic [QUEUE_QUANTITY*STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned Q    = QUEUE_QUANTITY;
  localparam int unsigned VC_W = $clog2(QUEUE_QUANTITY);
  localparam int unsigned DW   = BUF_WIDTH + 1;

  logic [Q-1:0]    pend_q, pend_d;
  logic [Q-1:0]    paused_q, paused_d;
  logic [Q-1:0]    elig;
  logic [DW-1:0]   slot_q [Q];
  logic [DW-1:0]   slot_d [Q];
  logic [VC_W-1:0] rr_q, rr_d;
  logic [VC_W-1:0] vc_q, vc_d;
  logic [DW-1:0]   data_q, data_d;
  logic            wr_q, wr_d;
  logic [VC_W-1:0] winner, idx;
  logic            grant, accept;

  // A VC raising pausa is masked in the same cycle, before its flag registers.
  always_comb begin
    paused_d = pausa | (paused_q & ~continuar);
    elig     = pend_q & ~paused_q & ~pausa;
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= Q; k++) begin
      idx = rr_q + VC_W'(k);
      if (!grant && elig[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
    if (!enb) begin
      grant = 1'b0;
    end
  end

  assign in_ready = enb & (~pend_q[in_vc] | (grant & (winner == in_vc)));
  assign accept   = in_valid & in_ready;

  // A refill of the VC being drained at the same edge keeps its slot pending.
  always_comb begin
    pend_d = pend_q;
    slot_d = slot_q;
    rr_d   = rr_q;
    wr_d   = 1'b0;
    vc_d   = vc_q;
    data_d = data_q;
    if (grant) begin
      wr_d           = 1'b1;
      vc_d           = winner;
      data_d         = slot_q[winner];
      rr_d           = winner;
      pend_d[winner] = 1'b0;
    end
    if (accept) begin
      pend_d[in_vc] = 1'b1;
      slot_d[in_vc] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      paused_q <= '0;
      rr_q     <= VC_W'(Q - 1);
      wr_q     <= 1'b0;
      vc_q     <= '0;
      data_q   <= '0;
      for (int unsigned i = 0; i < Q; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      paused_q <= paused_d;
      if (enb) begin
        pend_q <= pend_d;
        rr_q   <= rr_d;
        vc_q   <= vc_d;
        data_q <= data_d;
        slot_q <= slot_d;
      end
      wr_q <= wr_d;
    end
  end

  assign wr_en     = wr_q;
  assign vc_id     = vc_q;
  assign data_word = data_q;
  assign paused    = paused_q;
  assign idle      = ~|pend_q;

`ifdef QOS_INGRESS_STALL_CNT_EN
  logic [Q-1:0][STALL_CNT_W-1:0] stall_q;

  // Saturating count of enabled cycles a VC holds a word while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < Q; i++) begin
        if (enb && pend_q[i] && paused_q[i] && (stall_q[i] != '1)) begin
          stall_q[i] <= stall_q[i] + STALL_CNT_W'(1);
        end
      end
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_qos_ingress.sv
// Randomized and directed bench for qos_ingress against a cycle-level
// behavioural model of the VC slots, pause flags and round-robin order.
module tb_qos_ingress;

  localparam int unsigned Q  = 4;
  localparam int unsigned VW = 2;
  localparam int unsigned DW = 4;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enb = 1'b0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_vc = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [Q-1:0]  pausa = '0;
  logic [Q-1:0]  continuar = '0;
  logic          wr_en;
  logic [VW-1:0] vc_id;
  logic [DW-1:0] data_word;
  logic [Q-1:0]  paused;
  logic          idle;
`ifdef QOS_INGRESS_STALL_CNT_EN
  logic [Q*SW-1:0] stall_cnt;
`endif

  qos_ingress #(.QUEUE_QUANTITY(Q), .BUF_WIDTH(DW-1), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_vc(in_vc),
    .in_data(in_data), .in_ready(in_ready), .pausa(pausa), .continuar(continuar),
    .wr_en(wr_en), .vc_id(vc_id), .data_word(data_word), .paused(paused),
    .idle(idle)
`ifdef QOS_INGRESS_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  bit            m_pend   [Q];
  logic [DW-1:0] m_slot   [Q];
  bit            m_paused [Q];
  int            m_rr;
  bit            m_wr;
  int            m_vc;
  logic [DW-1:0] m_data;
  int unsigned   m_stall  [Q];
  int            wr_seq [$];

  function automatic void model_reset();
    for (int i = 0; i < Q; i++) begin
      m_pend[i] = 0; m_slot[i] = '0; m_paused[i] = 0; m_stall[i] = 0;
    end
    m_rr = Q - 1; m_wr = 0; m_vc = 0; m_data = '0;
    wr_seq.delete();
  endfunction

  function automatic int model_win(input bit en, input logic [Q-1:0] pa);
    if (!en) return -1;
    for (int k = 1; k <= Q; k++) begin
      int c;
      c = (m_rr + k) % Q;
      if (m_pend[c] && !m_paused[c] && !pa[c]) return c;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, compare outputs, then advance the model past the posedge.
  task automatic step(input bit en, input bit v, input int vc, input logic [DW-1:0] d,
                      input logic [Q-1:0] pa, input logic [Q-1:0] co);
    int  win;
    bit  rdy, acc, any;
    logic [Q-1:0] pv;
    @(negedge clk);
    enb = en; in_valid = v; in_vc = VW'(vc); in_data = d; pausa = pa; continuar = co;
    #1;
    win = model_win(en, pa);
    rdy = en && (!m_pend[vc] || win == vc);
    any = 0;
    for (int i = 0; i < Q; i++) begin
      pv[i] = m_paused[i];
      any   = any | m_pend[i];
    end
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("wr_en", 32'(wr_en), 32'(m_wr));
    chk("vc_id", 32'(vc_id), 32'(m_vc));
    chk("data_word", 32'(data_word), 32'(m_data));
    chk("paused", 32'(paused), 32'(pv));
    chk("idle", 32'(idle), 32'(!any));
`ifdef QOS_INGRESS_STALL_CNT_EN
    for (int i = 0; i < Q; i++) begin
      logic [SW-1:0] sc;
      sc = stall_cnt[i*SW +: SW];
      chk("stall_cnt", 32'(sc), m_stall[i]);
    end
`endif
    if (wr_en) wr_seq.push_back(int'(vc_id));
    acc = v && rdy;
    for (int i = 0; i < Q; i++) begin
      if (en && m_pend[i] && m_paused[i] && m_stall[i] < (2**SW - 1)) m_stall[i]++;
    end
    if (win >= 0) begin
      m_wr = 1; m_vc = win; m_data = m_slot[win]; m_pend[win] = 0; m_rr = win;
    end else begin
      m_wr = 0;
    end
    if (acc) begin
      m_pend[vc] = 1; m_slot[vc] = d;
    end
    for (int i = 0; i < Q; i++) begin
      if (pa[i]) m_paused[i] = 1;
      else if (co[i]) m_paused[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enb = 1'b0; in_valid = 1'b0; pausa = '0; continuar = '0;
    #1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_paused", 32'(paused), 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_vc_id", 32'(vc_id), 32'd0);
    chk("rst_data_word", 32'(data_word), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single word: VC2 data 0xA appears after the following edge
    step(1, 1, 2, 4'hA, '0, '0);
    step(1, 0, 0, '0, '0, '0);
    step(1, 0, 0, '0, '0, '0);
    chk("lat_wr_en", 32'(wr_en), 32'd1);
    chk("lat_vc_id", 32'(vc_id), 32'd2);
    chk("lat_data", 32'(data_word), 32'hA);

    // Fill three slots while paused, then reset mid-stream
    step(1, 1, 0, 4'h1, 4'hF, '0);
    step(1, 1, 1, 4'h2, 4'hF, '0);
    step(1, 1, 3, 4'h3, 4'hF, '0);
    chk("three_full_idle", 32'(idle), 32'd0);
    do_reset();

    // Fill all four, release, then refill VC0
    for (int i = 0; i < Q; i++) step(1, 1, i, DW'(i + 5), 4'hF, '0);
    step(1, 0, 0, '0, '0, 4'hF);
    step(1, 0, 0, '0, '0, '0);
    step(1, 0, 0, '0, '0, '0);
    step(1, 1, 0, 4'hC, '0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0, '0, '0);
    chk("fill_seq_len", 32'(wr_seq.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_seq.size(); i++)
      chk("fill_seq", 32'(wr_seq[i]), 32'(i % 4));

    // Pausing VC1 only blocks VC1
    do_reset();
    step(1, 1, 1, 4'h6, 4'b0010, '0);
    step(1, 1, 3, 4'h7, 4'b0010, '0);
    step(1, 0, 0, '0, 4'b0010, '0);
    step(1, 0, 0, '0, 4'b0010, '0);
    step(1, 0, 0, '0, '0, 4'b0010);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, '0);
    chk("pause_seq_len", 32'(wr_seq.size()), 32'd2);
    if (wr_seq.size() == 2) begin
      chk("pause_seq0", 32'(wr_seq[0]), 32'd3);
      chk("pause_seq1", 32'(wr_seq[1]), 32'd1);
    end

    // pausa and continuar together: pausa wins; then freeze with enb low
    do_reset();
    step(1, 1, 0, 4'h9, 4'b0001, 4'b0001);
    step(1, 0, 0, '0, '0, '0);
    chk("pausa_wins", 32'(paused[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 4'h4, '0, '0);
      chk("freeze_ready", 32'(in_ready), 32'd0);
      chk("freeze_wr_en", 32'(wr_en), 32'd0);
    end
    step(1, 0, 0, '0, '0, 4'b0001);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, '0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [Q-1:0] pa, co;
      for (int i = 0; i < Q; i++) begin
        pa[i] = ($urandom_range(0, 99) < 8);
        co[i] = ($urandom_range(0, 99) < 25);
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
           int'($urandom_range(0, Q - 1)), DW'($urandom), pa, co);
      if (n == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
